fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the byte-addressed, combinational-read instruction memory.
- Owns the program counter and drives the memory address.
- Captures each returned instruction word with its PC+4 into a small FIFO and presents it downstream to the decoder/controller over a valid/ready handshake.
- Accepts redirects (taken branch, J) from downstream; a redirect flushes the FIFO.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- DEPTH, 2, FIFO entries (power of two, >= 2).
- IMEM_ADDR_BITS, 12, instruction memory address width in bytes (4096 B).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- imem_addr  output  32  byte address to the instruction memory; equals the current PC.
- imem_instr  input  32  instruction word returned combinationally for imem_addr.
- redirect_valid  input  1  load redirect_pc into the PC and flush the FIFO.
- redirect_pc  input  32  new fetch address (branch/jump target).
- out_valid  output  1  FIFO head is valid.
- out_ready  input  1  consumer accepts the head this cycle.
- out_instr  output  32  FIFO head instruction.
- out_pc4  output  32  FIFO head PC+4, used for branch and jump target formation.
- misalign_err  output  1  sticky flag: a redirect had redirect_pc[1:0] != 0.

Behaviour:
- Reset (rst = 0, async):
  - PC = RESET_PC; FIFO empty (count = 0, pointers = 0).
  - out_valid = 0, out_instr = 0, out_pc4 = 0, misalign_err = 0.
- imem_addr = PC at all times (combinational from the PC register).
- Push condition (no redirect): count < DEPTH, or count == DEPTH with a pop in the same cycle.
- On push: {imem_instr, PC+4} is written at the write pointer and PC <= PC+4 (32-bit wrap, mod 2^32).
- No push: PC holds.
- Pop = out_valid & out_ready; the head advances.
- Outputs out_instr/out_pc4/out_valid come from the FIFO head register, with no combinational path from imem_instr.
- Latency:
  - First rising edge with rst = 1 pushes the word at RESET_PC; out_valid rises after that edge.
  - Steady-state throughput is 1 instruction per cycle while out_ready = 1.
- Redirect (highest priority):
  - A handshake occurring in the same cycle is honoured; the consumer keeps that word.
  - All FIFO entries are discarded: count = 0, pointers = 0, out_valid = 0 next cycle.
  - PC <= {redirect_pc[31:2], 2'b00}. No push that cycle.
  - If redirect_pc[1:0] != 0, misalign_err is set; it clears only on reset.
  - The first word from the new PC is pushed on the following edge.
- Back-to-back redirects: each one reloads the PC and the FIFO stays empty.
- Full with out_ready = 0: PC and FIFO hold. imem_addr stays stable, and the word is re-read from memory when space frees.
- Address wrap: only PC[IMEM_ADDR_BITS-1:0] is meaningful to memory. The PC itself carries the full 32 bits, and out_pc4 reports the full 32-bit value.
- The count register is log2(DEPTH)+1 bits wide. Pointers wrap modulo DEPTH.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined:
  - Adds output port fetch_count (32 bits) and stall_count (32 bits), both reset to 0.
  - fetch_count increments on every pop.
  - stall_count increments each cycle with out_valid = 1 and out_ready = 0.
  - Both counters saturate at 32'hFFFF_FFFF and are not cleared by a redirect.
- When not defined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, memory holds 0x20010000 @0 and 0x20020000 @4, out_ready = 1:
  - Cycle 1: out_valid = 1, out_instr = 0x20010000, out_pc4 = 0x4.
  - Next cycle: out_instr = 0x20020000, out_pc4 = 0x8.
  - imem_addr increments by 4 per cycle.
- out_ready = 0 for 5 cycles after reset:
  - FIFO fills to 2, then imem_addr holds at 0x8.
  - On release: words @0, @4, @8 delivered in order, with no loss or duplication.
- Redirect to 0x14 while the FIFO holds 2 entries and out_ready = 1:
  - The head transfers that cycle; the second entry is discarded; out_valid = 0 next cycle.
  - The cycle after that: out_instr = word @0x14, out_pc4 = 0x18.
- Redirect to 0x2E:
  - imem_addr becomes 0x2C and misalign_err = 1.
  - misalign_err stays 1 through later redirects; an async rst pulse mid-cycle clears it and sets imem_addr = 0 immediately.
- Redirect asserted on two consecutive cycles (0x30 then 0x40):
  - Only word @0x40 appears; out_pc4 = 0x44.
- With FETCH_PERF_CNT_EN defined:
  - 10 pops and 3 stall cycles give fetch_count = 10 and stall_count = 3.
  - Both counters are unchanged by an intervening redirect.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the combinational instruction memory and
// queues {instr, PC+4} in a small FIFO. Optional FETCH_PERF_CNT_EN adds fetch/stall counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          DEPTH          = 2,
  parameter int          IMEM_ADDR_BITS = 12
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc4,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count,
`endif
  output logic        misalign_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fetch_unit: DEPTH must be a power of two >= 2");
  end
  if (IMEM_ADDR_BITS < 3 || IMEM_ADDR_BITS > 32) begin : g_bad_abits
    $error("fetch_unit: IMEM_ADDR_BITS out of range");
  end

  logic [31:0]   pc_q, pc_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   instr_d [DEPTH];
  logic [31:0]   pc4_q   [DEPTH];
  logic [31:0]   pc4_d   [DEPTH];
  logic          misalign_q, misalign_d;
  logic          push, pop;
  logic [31:0]   pc_plus4;

  // Handshake: a word moves downstream on a cycle where out_valid and out_ready are both 1;
  // out_valid never depends on out_ready, and the head is only ever a registered value.
  assign out_valid    = (count_q != '0);
  assign out_instr    = instr_q[rptr_q];
  assign out_pc4      = pc4_q[rptr_q];
  assign imem_addr    = pc_q;
  assign misalign_err = misalign_q;
  assign pc_plus4     = pc_q + 32'd4;

  always_comb begin
    pop        = out_valid & out_ready;
    push       = !redirect_valid && ((count_q < CW'(DEPTH)) || pop);
    pc_d       = pc_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    instr_d    = instr_q;
    pc4_d      = pc4_q;
    misalign_d = misalign_q;
    if (redirect_valid) begin
      // Redirect flushes everything; a same-cycle pop has already been taken by the consumer.
      pc_d    = {redirect_pc[31:2], 2'b00};
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      if (redirect_pc[1:0] != 2'b00) misalign_d = 1'b1;
    end else begin
      if (push) begin
        instr_d[wptr_q] = imem_instr;
        pc4_d[wptr_q]   = pc_plus4;
        wptr_d          = wptr_q + 1'b1;
        pc_d            = pc_plus4;
      end
      if (pop) rptr_d = rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc4_q[i]   <= '0;
      end
    end else begin
      pc_q       <= pc_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
      instr_q    <= instr_d;
      pc4_q      <= pc4_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d, stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (pop && fetch_cnt_q != 32'hFFFF_FFFF) fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (out_valid && !out_ready && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory word at byte address a is 0x2000_0000 + ((a/4 + 1) << 16).
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc4;
  logic        misalign_err;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] mem [1024];

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_addr[11:2]];

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc4        (out_pc4),
`ifdef FETCH_PERF_CNT_EN
    .fetch_count    (fetch_count),
    .stall_count    (stall_count),
`endif
    .misalign_err   (misalign_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset across a falling edge, release mid-cycle so the next posedge is the first live one.
  task automatic do_reset(input logic ready);
    @(negedge clk);
    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = ready;
    #2;
    rst = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h2000_0000 + ((i + 1) << 16);
    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b1;
    #3;
    check("rst_valid", {31'b0, out_valid}, 32'h0);
    check("rst_instr", out_instr, 32'h0);
    check("rst_pc4", out_pc4, 32'h0);
    check("rst_misalign", {31'b0, misalign_err}, 32'h0);
    check("rst_addr", imem_addr, 32'h0);

    // Streaming at one word per cycle
    do_reset(1'b1);
    tick();
    check("s1_valid", {31'b0, out_valid}, 32'h1);
    check("s1_instr", out_instr, 32'h2001_0000);
    check("s1_pc4", out_pc4, 32'h4);
    check("s1_addr", imem_addr, 32'h4);
    tick();
    check("s2_instr", out_instr, 32'h2002_0000);
    check("s2_pc4", out_pc4, 32'h8);
    check("s2_addr", imem_addr, 32'h8);

    // Back-pressure fills the FIFO, then drains in order
    do_reset(1'b0);
    tick();
    check("bp1_addr", imem_addr, 32'h4);
    tick();
    check("bp2_addr", imem_addr, 32'h8);
    tick(); tick(); tick();
    check("bp5_addr", imem_addr, 32'h8);
    check("bp5_instr", out_instr, 32'h2001_0000);
    out_ready = 1'b1;
    tick();
    check("bp6_instr", out_instr, 32'h2002_0000);
    check("bp6_pc4", out_pc4, 32'h8);
    tick();
    check("bp7_instr", out_instr, 32'h2003_0000);
    check("bp7_pc4", out_pc4, 32'hC);
    check("bp7_addr", imem_addr, 32'h10);

    // Redirect with two entries queued
    do_reset(1'b0);
    tick(); tick();
    check("rd_pre_instr", out_instr, 32'h2001_0000);
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h14;
    tick();
    redirect_valid = 1'b0;
    check("rd_flush_valid", {31'b0, out_valid}, 32'h0);
    check("rd_flush_addr", imem_addr, 32'h14);
    tick();
    check("rd_new_valid", {31'b0, out_valid}, 32'h1);
    check("rd_new_instr", out_instr, 32'h2006_0000);
    check("rd_new_pc4", out_pc4, 32'h18);

    // Misaligned redirect, sticky flag, async reset clears it
    redirect_valid = 1'b1;
    redirect_pc    = 32'h2E;
    tick();
    check("mis_addr", imem_addr, 32'h2C);
    check("mis_flag", {31'b0, misalign_err}, 32'h1);
    redirect_pc = 32'h30;
    tick();
    redirect_valid = 1'b0;
    check("mis_sticky", {31'b0, misalign_err}, 32'h1);
    check("mis_aligned_addr", imem_addr, 32'h30);
    tick();
    rst = 1'b0;
    #1;
    check("arst_flag", {31'b0, misalign_err}, 32'h0);
    check("arst_addr", imem_addr, 32'h0);
    check("arst_valid", {31'b0, out_valid}, 32'h0);
    #1;
    rst = 1'b1;

    // Back-to-back redirects
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h30;
    tick();
    check("b2b1_valid", {31'b0, out_valid}, 32'h0);
    redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    check("b2b2_valid", {31'b0, out_valid}, 32'h0);
    check("b2b2_addr", imem_addr, 32'h40);
    tick();
    check("b2b_instr", out_instr, 32'h2011_0000);
    check("b2b_pc4", out_pc4, 32'h44);

    // 32-bit PC wrap
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_instr", out_instr, 32'h2400_0000);
    check("wrap_pc4", out_pc4, 32'h0);
    check("wrap_next_addr", imem_addr, 32'h0);
    tick();
    check("wrap2_instr", out_instr, 32'h2001_0000);
    check("wrap2_pc4", out_pc4, 32'h4);

`ifdef FETCH_PERF_CNT_EN
    do_reset(1'b0);
    #1;
    check("perf_rst_fetch", fetch_count, 32'h0);
    check("perf_rst_stall", stall_count, 32'h0);
    for (int i = 0; i < 4; i++) tick();
    check("perf_stall3", stall_count, 32'd3);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("perf_fetch5", fetch_count, 32'd5);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    redirect_valid = 1'b0;
    check("perf_redir_fetch", fetch_count, 32'd6);
    check("perf_redir_stall", stall_count, 32'd3);
    for (int i = 0; i < 5; i++) tick();
    check("perf_fetch10", fetch_count, 32'd10);
    check("perf_stall_final", stall_count, 32'd3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
